i2c_slave_responder: RTL

I2C_SLAVE_RESPONDER -- requirements
Module: i2c_slave_responder

---
 rtl/i2c_slave_responder.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_slave_responder.sv
// I2C slave with a small register file: bus writes set a pointer then fill registers, bus reads stream them back.
// Optional 3-sample majority glitch filter on SCL/SDA when I2C_SLAVE_GLITCH_FILTER_EN is defined.
module i2c_slave_responder #(
  parameter logic [6:0] SLAVE_ADDRESS = 7'h50,
  parameter int         DATA_LENGTH   = 8,
  parameter int         REG_DEPTH     = 16
) (
  input  logic                         pclk,
  input  logic                         areset,
  input  logic                         scl_i,
  input  logic                         sda_i,
  output logic                         sda_oe,
  output logic                         wr_valid,
  output logic [$clog2(REG_DEPTH)-1:0] wr_addr,
  output logic [DATA_LENGTH-1:0]       wr_data,
  output logic                         busy
);

  localparam int PTR_W = $clog2(REG_DEPTH);
  localparam int SW    = (DATA_LENGTH > 8) ? DATA_LENGTH : 8;
  localparam int CW    = $clog2(SW + 1);
  localparam logic [CW-1:0] ADDR_BITS = CW'(8);
  localparam logic [CW-1:0] DATA_BITS = CW'(DATA_LENGTH);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP
  } state_t;

  logic [1:0] scl_sync, sda_sync;
  logic       scl_l, sda_l, scl_p, sda_p;

  always_ff @(posedge pclk) begin
    if (areset) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], scl_i};
      sda_sync <= {sda_sync[0], sda_i};
    end
  end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  // Majority of the current and two previous samples, registered: single-pclk pulses never win.
  logic [1:0] scl_hist, sda_hist;
  logic       scl_f, sda_f;

  always_ff @(posedge pclk) begin
    if (areset) begin
      scl_hist <= 2'b11;
      sda_hist <= 2'b11;
      scl_f    <= 1'b1;
      sda_f    <= 1'b1;
    end else begin
      scl_hist <= {scl_hist[0], scl_sync[1]};
      sda_hist <= {sda_hist[0], sda_sync[1]};
      scl_f    <= (scl_sync[1] & scl_hist[0]) | (scl_sync[1] & scl_hist[1]) | (scl_hist[0] & scl_hist[1]);
      sda_f    <= (sda_sync[1] & sda_hist[0]) | (sda_sync[1] & sda_hist[1]) | (sda_hist[0] & sda_hist[1]);
    end
  end

  assign scl_l = scl_f;
  assign sda_l = sda_f;
`else
  assign scl_l = scl_sync[1];
  assign sda_l = sda_sync[1];
`endif

  always_ff @(posedge pclk) begin
    if (areset) begin
      scl_p <= 1'b1;
      sda_p <= 1'b1;
    end else begin
      scl_p <= scl_l;
      sda_p <= sda_l;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  = scl_l & ~scl_p;
  assign scl_fall  = ~scl_l & scl_p;
  assign start_det = scl_l & scl_p & sda_p & ~sda_l;
  assign stop_det  = scl_l & scl_p & ~sda_p & sda_l;

  state_t                   state, state_nx;
  logic [SW-1:0]            shift, shift_nx, shift_in;
  logic [CW-1:0]            bit_cnt, bit_cnt_nx, cnt_inc;
  logic [PTR_W-1:0]         ptr, ptr_nx;
  logic                     first_byte, first_nx, rw, rw_nx;
  logic                     sda_oe_nx, wr_valid_nx, busy_nx, rf_we;
  logic [PTR_W-1:0]         wr_addr_nx;
  logic [DATA_LENGTH-1:0]   wr_data_nx;
  logic [DATA_LENGTH-1:0]   regfile [REG_DEPTH];

  assign shift_in = {shift[SW-2:0], sda_l};
  assign cnt_inc  = bit_cnt + 1'b1;

  always_ff @(posedge pclk) begin
    if (areset) begin
      state      <= IDLE;
      shift      <= '0;
      bit_cnt    <= '0;
      ptr        <= '0;
      first_byte <= 1'b0;
      rw         <= 1'b0;
      sda_oe     <= 1'b0;
      wr_valid   <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nx;
      shift      <= shift_nx;
      bit_cnt    <= bit_cnt_nx;
      ptr        <= ptr_nx;
      first_byte <= first_nx;
      rw         <= rw_nx;
      sda_oe     <= sda_oe_nx;
      wr_valid   <= wr_valid_nx;
      wr_addr    <= wr_addr_nx;
      wr_data    <= wr_data_nx;
      busy       <= busy_nx;
    end
  end

  always_ff @(posedge pclk) begin
    if (areset) begin
      for (int i = 0; i < REG_DEPTH; i++) regfile[i] <= '0;
    end else if (rf_we) begin
      regfile[ptr] <= shift_in[DATA_LENGTH-1:0];
    end
  end

  // Bits are sampled on SCL rise; SDA drive only changes on SCL fall. Acknowledge states
  // hold the line through the 9th period and the following state releases it on its first fall.
  always_comb begin
    state_nx    = state;
    shift_nx    = shift;
    bit_cnt_nx  = bit_cnt;
    ptr_nx      = ptr;
    first_nx    = first_byte;
    rw_nx       = rw;
    sda_oe_nx   = sda_oe;
    wr_valid_nx = 1'b0;
    wr_addr_nx  = wr_addr;
    wr_data_nx  = wr_data;
    busy_nx     = busy;
    rf_we       = 1'b0;

    if (stop_det) begin
      state_nx   = IDLE;
      sda_oe_nx  = 1'b0;
      shift_nx   = '0;
      bit_cnt_nx = '0;
    end else if (start_det) begin
      state_nx   = ADDR;
      sda_oe_nx  = 1'b0;
      shift_nx   = '0;
      bit_cnt_nx = '0;
    end else begin
      case (state)
        ADDR: if (scl_rise) begin
          shift_nx   = shift_in;
          bit_cnt_nx = cnt_inc;
          if (cnt_inc == ADDR_BITS) begin
            bit_cnt_nx = '0;
            if (shift_in[7:1] == SLAVE_ADDRESS) begin
              state_nx = ADDR_ACK;
              rw_nx    = shift_in[0];
            end else begin
              state_nx = WAIT_STOP;
            end
          end
        end
        ADDR_ACK: if (scl_fall) begin
          sda_oe_nx = 1'b1;
        end else if (scl_rise) begin
          bit_cnt_nx = '0;
          shift_nx   = '0;
          if (rw) begin
            state_nx                  = RD_BYTE;
            shift_nx[DATA_LENGTH-1:0] = regfile[ptr];
          end else begin
            state_nx = WR_BYTE;
            first_nx = 1'b1;
          end
        end
        WR_BYTE: if (scl_fall) begin
          sda_oe_nx = 1'b0;
        end else if (scl_rise) begin
          shift_nx   = shift_in;
          bit_cnt_nx = cnt_inc;
          if (cnt_inc == DATA_BITS) begin
            bit_cnt_nx = '0;
            state_nx   = WR_ACK;
            if (first_byte) begin
              ptr_nx   = shift_in[PTR_W-1:0];
              first_nx = 1'b0;
            end else begin
              rf_we       = 1'b1;
              wr_valid_nx = 1'b1;
              wr_addr_nx  = ptr;
              wr_data_nx  = shift_in[DATA_LENGTH-1:0];
              ptr_nx      = ptr + 1'b1;
            end
          end
        end
        WR_ACK: if (scl_fall) begin
          sda_oe_nx = 1'b1;
        end else if (scl_rise) begin
          state_nx   = WR_BYTE;
          shift_nx   = '0;
          bit_cnt_nx = '0;
        end
        RD_BYTE: if (scl_fall) begin
          sda_oe_nx = ~shift[DATA_LENGTH-1];
        end else if (scl_rise) begin
          shift_nx   = {shift[SW-2:0], 1'b0};
          bit_cnt_nx = cnt_inc;
          if (cnt_inc == DATA_BITS) begin
            bit_cnt_nx = '0;
            ptr_nx     = ptr + 1'b1;
            state_nx   = RD_ACK;
          end
        end
        RD_ACK: if (scl_fall) begin
          sda_oe_nx = 1'b0;
        end else if (scl_rise) begin
          if (sda_l) begin
            state_nx = WAIT_STOP;
          end else begin
            state_nx                  = RD_BYTE;
            shift_nx                  = '0;
            shift_nx[DATA_LENGTH-1:0] = regfile[ptr];
          end
        end
        IDLE, WAIT_STOP: ;
        default: state_nx = IDLE;
      endcase
    end

    if (state_nx == ADDR_ACK) busy_nx = 1'b1;
    else if (state_nx == IDLE || state_nx == WAIT_STOP) busy_nx = 1'b0;
  end

endmodule
